// File: rtl/data_mem_lsu.sv
// Data memory with integrated load/store unit: byte/halfword/word access,
// load extension, misalignment suppression and sticky first-fault capture.
module data_mem_lsu #(
  parameter int DEPTH     = 64,
  parameter int ADDR_BITS = 6
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic        i_fault_clr,
  output logic [31:0] o_rd_data,
  output logic        o_misalign,
  output logic        o_fault,
  output logic [31:0] o_fault_addr
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Whole memory held as one flat vector so the array clears in a single reset
  logic [DEPTH*32-1:0]  mem_q;
  logic [ADDR_BITS-1:0] word_idx;
  logic [31:0]          rd_word;
  logic [31:0]          wr_word;
  logic                 wr_en;
  logic                 size_bad;

  function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic uns);
    logic signed [7:0] sb;
    sb = b;
    return uns ? 32'(b) : 32'(sb);
  endfunction

  function automatic logic [31:0] extend_half(input logic [15:0] h, input logic uns);
    logic signed [15:0] sh;
    sh = h;
    return uns ? 32'(h) : 32'(sh);
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] old_w,
                                              input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] merged;
    merged = old_w;
    case (size)
      SZ_BYTE: merged[{lane, 3'b000} +: 8]     = data[7:0];
      SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = data[15:0];
      default: merged = data;
    endcase
    return merged;
  endfunction

  assign word_idx = i_addr[ADDR_BITS+1:2];
  assign rd_word  = mem_q[{word_idx, 5'b00000} +: 32];

  always_comb begin
    size_bad = 1'b0;
    case (i_size)
      SZ_BYTE: size_bad = 1'b0;
      SZ_HALF: size_bad = i_addr[0];
      SZ_WORD: size_bad = |i_addr[1:0];
      default: size_bad = 1'b1;
    endcase
  end

  assign o_misalign = (i_mem_rd | i_mem_wr) & size_bad;
  assign wr_en      = i_mem_wr & ~o_misalign;
  assign wr_word    = merge_store(rd_word, i_wr_data, i_size, i_addr[1:0]);

  // Loads are zero-latency and see the pre-write word on same-cycle store
  always_comb begin
    o_rd_data = '0;
    if (i_mem_rd && !o_misalign) begin
      case (i_size)
        SZ_BYTE: o_rd_data = extend_byte(rd_word[{i_addr[1:0], 3'b000} +: 8], i_unsigned);
        SZ_HALF: o_rd_data = extend_half(rd_word[{i_addr[1], 4'b0000} +: 16], i_unsigned);
        default: o_rd_data = rd_word;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_q <= '0;
    end else if (wr_en) begin
      mem_q[{word_idx, 5'b00000} +: 32] <= wr_word;
    end
  end

  // Capture only the first fault; a new capture overrides a same-cycle clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fault      <= 1'b0;
      o_fault_addr <= '0;
    end else if (o_misalign && !o_fault) begin
      o_fault      <= 1'b1;
      o_fault_addr <= i_addr;
    end else if (i_fault_clr) begin
      o_fault      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: directed plan plus randomized traffic
// compared against an array-based behavioural memory model.
module tb_data_mem_lsu;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata;
  logic        rd, wr, uns, clr;
  logic [1:0]  size;
  logic [31:0] rd_data, fault_addr;
  logic        misalign, fault;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_mem [DEPTH];
  logic        m_fault;
  logic [31:0] m_faddr;
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  data_mem_lsu #(.DEPTH(DEPTH), .ADDR_BITS(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_wr_data(wdata),
    .i_mem_rd(rd), .i_mem_wr(wr), .i_size(size), .i_unsigned(uns),
    .i_fault_clr(clr), .o_rd_data(rd_data), .o_misalign(misalign),
    .o_fault(fault), .o_fault_addr(fault_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    m_fault = 1'b0;
    m_faddr = 32'h0;
  endtask

  function automatic logic model_mis(input logic r, input logic w, input logic [1:0] s,
                                     input logic [31:0] a);
    if (!r && !w) return 1'b0;
    case (s)
      2'd0:    return 1'b0;
      2'd1:    return (a % 2) != 0;
      2'd2:    return (a % 4) != 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic r, input logic [1:0] s, input logic u,
                                             input logic [31:0] a, input logic mis);
    logic [31:0] w, v;
    if (!r || mis) return 32'h0;
    w = m_mem[(a / 4) % DEPTH];
    case (s)
      2'd0: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (!u && v >= 128) v = v + 32'hFFFFFF00;
      end
      2'd1: begin
        v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        if (!u && v >= 32768) v = v + 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic model_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    int idx;
    logic [31:0] mask, sh;
    idx = (a / 4) % DEPTH;
    case (s)
      2'd0: begin sh = 8 * (a % 4);  mask = 32'hFF << sh; end
      2'd1: begin sh = 16 * ((a / 2) % 2); mask = 32'hFFFF << sh; end
      default: begin sh = 0; mask = 32'hFFFFFFFF; end
    endcase
    m_mem[idx] = (m_mem[idx] & ~mask) | ((d << sh) & mask);
  endtask

  // One clock of traffic: drive at negedge, check combinational outputs, then state after edge
  task automatic access(input logic r, input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d, input logic c,
                        input string tag);
    logic exp_mis;
    logic [31:0] exp_rd;
    @(negedge clk);
    rd = r; wr = w; size = s; uns = u; addr = a; wdata = d; clr = c;
    exp_mis = model_mis(r, w, s, a);
    exp_rd  = model_load(r, s, u, a, exp_mis);
    #1;
    check({tag, "_mis"}, {31'b0, misalign}, {31'b0, exp_mis});
    check({tag, "_rd"}, rd_data, exp_rd);
    last_rd = rd_data;
    if (w && !exp_mis) model_store(s, a, d);
    if (exp_mis && !m_fault) begin
      m_fault = 1'b1;
      m_faddr = a;
    end else if (c) begin
      m_fault = 1'b0;
    end
    @(posedge clk);
    #1;
    check({tag, "_flt"}, {31'b0, fault}, {31'b0, m_fault});
    check({tag, "_fa"}, fault_addr, m_faddr);
    rd = 1'b0; wr = 1'b0; clr = 1'b0;
  endtask

  initial begin
    logic [1:0]  s;
    logic [31:0] a;
    rst_n = 1'b0;
    rd = 1'b0; wr = 1'b0; size = 2'd0; uns = 1'b0; addr = '0; wdata = '0; clr = 1'b0;
    model_reset();
    #12 rst_n = 1'b1;
    #1;
    check("rst_fault", {31'b0, fault}, 32'h0);
    check("rst_faddr", fault_addr, 32'h0);

    access(1, 0, 2'd2, 0, 32'h00, 0, 0, "lw00");  check("lw00_c", last_rd, 32'h0);
    access(1, 0, 2'd2, 0, 32'h04, 0, 0, "lw04");  check("lw04_c", last_rd, 32'h0);
    access(1, 0, 2'd2, 0, 32'hFC, 0, 0, "lwfc");  check("lwfc_c", last_rd, 32'h0);

    access(0, 1, 2'd2, 0, 32'h10, 32'h8899AABB, 0, "sw10");
    access(1, 0, 2'd2, 0, 32'h10, 0, 0, "lw10");  check("lw10_c", last_rd, 32'h8899AABB);
    access(1, 0, 2'd0, 0, 32'h10, 0, 0, "lb10");  check("lb10_c", last_rd, 32'hFFFFFFBB);
    access(1, 0, 2'd0, 1, 32'h13, 0, 0, "lbu13"); check("lbu13_c", last_rd, 32'h00000088);
    access(1, 0, 2'd1, 0, 32'h12, 0, 0, "lh12");  check("lh12_c", last_rd, 32'hFFFF8899);
    access(1, 0, 2'd1, 1, 32'h10, 0, 0, "lhu10"); check("lhu10_c", last_rd, 32'h0000AABB);

    access(0, 1, 2'd0, 0, 32'h11, 32'h11223344, 0, "sb11");
    access(1, 0, 2'd2, 0, 32'h10, 0, 0, "lw_sb"); check("lw_sb_c", last_rd, 32'h889944BB);
    access(0, 1, 2'd1, 0, 32'h12, 32'h0000CAFE, 0, "sh12");
    access(1, 0, 2'd2, 0, 32'h10, 0, 0, "lw_sh"); check("lw_sh_c", last_rd, 32'hCAFE44BB);

    access(1, 1, 2'd2, 0, 32'h10, 32'h12345678, 0, "rdw"); check("rdw_c", last_rd, 32'hCAFE44BB);
    access(1, 0, 2'd2, 0, 32'h10, 0, 0, "rdw_nx"); check("rdw_nx_c", last_rd, 32'h12345678);
    access(0, 1, 2'd2, 0, 32'h110, 32'hDEADBEEF, 0, "sw_wrap");
    access(1, 0, 2'd2, 0, 32'h10, 0, 0, "lw_wrap"); check("lw_wrap_c", last_rd, 32'hDEADBEEF);

    access(0, 1, 2'd2, 0, 32'h20, 32'hA5A5A5A5, 0, "sw20");
    access(0, 1, 2'd2, 0, 32'h22, 32'hFFFFFFFF, 0, "sw22");
    check("sw22_fa_c", fault_addr, 32'h22);
    access(1, 0, 2'd2, 0, 32'h20, 0, 0, "lw20"); check("lw20_c", last_rd, 32'hA5A5A5A5);
    access(1, 0, 2'd1, 0, 32'h05, 0, 0, "lh05"); check("lh05_fa_c", fault_addr, 32'h22);
    access(0, 0, 2'd0, 0, 32'h0, 0, 1, "clr");   check("clr_c", {31'b0, fault}, 32'h0);
    access(1, 0, 2'd2, 0, 32'h31, 0, 1, "clr_lw31");
    check("clr_lw31_c", fault_addr, 32'h31);
    access(1, 0, 2'd3, 0, 32'h40, 0, 1, "clr_held"); check("clr_held_c", fault_addr, 32'h31);

    // Asynchronous reset between edges while a store is pending
    access(1, 0, 2'd0, 0, 32'h41, 0, 0, "pre_rst");
    @(negedge clk);
    rd = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h10; wdata = 32'h55555555;
    #1 check("pre_async_rd", rd_data, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1;
    check("async_rd", rd_data, 32'h0);
    check("async_flt", {31'b0, fault}, 32'h0);
    check("async_fa", fault_addr, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    rd = 1'b0; wr = 1'b0;
    model_reset();
    access(1, 0, 2'd2, 0, 32'h10, 0, 0, "post_rst10"); check("post_rst10_c", last_rd, 32'h0);
    access(1, 0, 2'd2, 0, 32'h20, 0, 0, "post_rst20"); check("post_rst20_c", last_rd, 32'h0);

    for (int i = 0; i < 400; i++) begin
      s = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      a = $urandom % 512;
      if ($urandom % 4 != 0) a = a & ~32'(s == 2'd2 ? 3 : (s == 2'd1 ? 1 : 0));
      access(1'($urandom % 2), 1'($urandom % 2), s, 1'($urandom % 2), a, $urandom,
             1'($urandom % 10 == 0), "rnd");
    end
    for (int i = 0; i < DEPTH; i++) access(1, 0, 2'd2, 0, 32'(i * 4), 0, 0, "dump");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
